multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Issue/retire controller between the EX stage and the shared MultDiv unit; owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from EX, launches MultDiv and holds `stall_req` until the result returns, then writes {HI,LO}.
- Executes MTHI/MTLO in one cycle and supplies MFHI/MFLO read data.
- Guards against a hung unit with a watchdog and short-circuits divide-by-zero.

Parameters:
- TIMEOUT, 64, max BUSY cycles waiting for `md_done` before abort (≥2).
- CNT_W, 7, watchdog counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_funct  in  `FUNCT_BUS (6)  funct field of EX instruction.
- ex_op1  in  `DATA_BUS (32)  rs value.
- ex_op2  in  `DATA_BUS (32)  rt value.
- stall_all  in  1  global pipeline stall (EX does not advance).
- stall_req  out  1  request EX/earlier stages to stall.
- hilo_rdata  out  32  HI if ex_funct==`FUNCT_MFHI, else LO.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_funct  out  6  funct to MultDiv; latched op while BUSY, 6'b000000 otherwise.
- md_op1  out  32  latched operand 1.
- md_op2  out  32  latched operand 2.
- md_stall  out  1  passthrough of stall_all.
- md_done  in  1  MultDiv completion, one cycle.
- md_result  in  `DOUBLE_DATA_BUS (64)  {HI,LO} result.
- div0  out  1  one-cycle pulse: DIV/DIVU with op2==0 retired.
- timeout_err  out  1  one-cycle pulse: watchdog abort.

Behaviour:
- Reset (rst==0, async): state=IDLE; hi, lo, md_op1, md_op2 = 0; md_funct=0; counter=0; div0, timeout_err = 0.
- Decode: `md_op` = ex_valid & funct ∈ {MULT, MULTU, DIV, DIVU}. `mt_op` = ex_valid & funct ∈ {MTHI, MTLO}.
- Accept condition: state==IDLE & !stall_all.
- States:
  - IDLE
    - accept & md_op & divide & ex_op2==0: no launch; hi/lo unchanged; div0=1 next cycle; next state = DONE. stall_req=0 (completes in 1 cycle).
    - accept & md_op (otherwise): latch funct/op1/op2; counter=0; next = BUSY. stall_req=1 combinationally in the accept cycle.
    - accept & mt_op: HI or LO <= ex_op1 at this edge; stay in IDLE; no stall.
  - BUSY
    - stall_req = !md_done.
    - counter increments each cycle.
    - md_done: hi<=md_result[63:32], lo<=md_result[31:0]; md_funct<=0; next = IDLE if !stall_all, else DONE.
    - !md_done & counter==TIMEOUT-1: abort; hi/lo unchanged; timeout_err pulse; md_funct<=0; next = DONE.
  - DONE: retired instruction still sits in EX under stall_all. stall_req=0; no accept; go to IDLE when !stall_all.
- No re-issue: the same EX instruction is never launched twice.
- Latency: MultDiv latency + 0 cycles. stall_req falls in the same cycle md_done is high.
- md_done outside BUSY is ignored.
- MFHI/MFLO: combinational read of the current registers. No hazard exists, because EX is stalled until HI/LO are written.
- Simultaneous md_done and watchdog expiry: md_done wins.
- stall_all high in BUSY: unit continues; md_stall forwards stall_all.

Test Plan:
- DIVU op1=142, op2=12 -> stall_req high from accept until md_done; then hi=32'd10, lo=32'd11; state IDLE.
- DIV op1=0x80000012, op2=0x12 -> lo=0xF8E38E3A, hi=0xFFFFFFFE; MFHI next cycle gives hilo_rdata=0xFFFFFFFE.
- MULTU 12×12 then MTLO 0x55 -> hi=0, lo=0x90, then lo=0x55 with no stall on the MTLO.
- DIVU op2=0 -> no md_funct launch, div0 pulses once, hi/lo unchanged, stall_req never asserts.
- stall_all held high across the md_done cycle -> state DONE, no second launch (md_funct stays 0); IDLE after stall_all drops.
- Stubbed unit never asserts md_done -> timeout_err after TIMEOUT cycles. Separately, rst pulled low mid-BUSY -> immediate IDLE with hi=lo=0 and stall_req=0.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Issue/retire controller between EX and the shared MultDiv unit.
// Owns HI/LO, runs MTHI/MTLO and feeds MFHI/MFLO read data.
module multdiv_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        stall_all,
  output logic        stall_req,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [5:0]  md_funct,
  output logic [31:0] md_op1,
  output logic [31:0] md_op2,
  output logic        md_stall,
  input  logic        md_done,
  input  logic [63:0] md_result,
  output logic        div0,
  output logic        timeout_err
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [5:0]       funct_q, funct_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div0_q, div0_d;
  logic             tout_q, tout_d;

  logic is_div;
  logic md_op;
  logic mt_op;
  logic accept;

  always_comb begin
    is_div = (ex_funct == F_DIV) || (ex_funct == F_DIVU);
    md_op  = ex_valid && ((ex_funct == F_MULT) ||
                          (ex_funct == F_MULTU) || is_div);
    mt_op  = ex_valid && ((ex_funct == F_MTHI) ||
                          (ex_funct == F_MTLO));
    accept = (state_q == IDLE) && !stall_all;
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    funct_d   = funct_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cnt_d     = cnt_q;
    div0_d    = 1'b0;
    tout_d    = 1'b0;
    stall_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && md_op) begin
          // Divide by zero retires at once without touching the unit.
          if (is_div && (ex_op2 == 32'd0)) begin
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            funct_d   = ex_funct;
            op1_d     = ex_op1;
            op2_d     = ex_op2;
            cnt_d     = '0;
            state_d   = BUSY;
            stall_req = 1'b1;
          end
        end else if (accept && mt_op) begin
          if (ex_funct == F_MTHI) begin
            hi_d = ex_op1;
          end else begin
            lo_d = ex_op1;
          end
        end
      end
      BUSY: begin
        stall_req = !md_done;
        cnt_d     = cnt_q + CNT_W'(1);
        if (md_done) begin
          hi_d    = md_result[63:32];
          lo_d    = md_result[31:0];
          funct_d = 6'd0;
          state_d = stall_all ? DONE : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          funct_d = 6'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Retired op may still sit in EX; wait for it to leave.
        if (!stall_all) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      funct_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      funct_q <= funct_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
      tout_q  <= tout_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign hilo_rdata  = (ex_funct == F_MFHI) ? hi_q : lo_q;
  assign md_funct    = funct_q;
  assign md_op1      = op1_q;
  assign md_op2      = op2_q;
  assign md_stall    = stall_all;
  assign div0        = div0_q;
  assign timeout_err = tout_q;

  logic unused_mflo;
  assign unused_mflo = (F_MFLO == 6'd0);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl; the bench itself plays the
// MultDiv unit and supplies hand-computed results.
module tb_multdiv_ctrl;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  ex_funct;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        stall_all;
  logic        stall_req;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  md_funct;
  logic [31:0] md_op1;
  logic [31:0] md_op2;
  logic        md_stall;
  logic        md_done;
  logic [63:0] md_result;
  logic        div0;
  logic        timeout_err;

  int npass = 0;
  int nfail = 0;
  int n;

  multdiv_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_funct   (ex_funct),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .stall_all  (stall_all),
    .stall_req  (stall_req),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo),
    .md_funct   (md_funct),
    .md_op1     (md_op1),
    .md_op2     (md_op2),
    .md_stall   (md_stall),
    .md_done    (md_done),
    .md_result  (md_result),
    .div0       (div0),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b);
    ex_valid = 1'b1;
    ex_funct = f;
    ex_op1   = a;
    ex_op2   = b;
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    ex_valid  = 1'b0;
    ex_funct  = 6'd0;
    ex_op1    = 32'd0;
    ex_op2    = 32'd0;
    stall_all = 1'b0;
    md_done   = 1'b0;
    md_result = 64'd0;
    tick();
    tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_funct", md_funct, 0);
    check("rst_stall", stall_req, 0);
    check("rst_div0", div0, 0);
    check("rst_tout", timeout_err, 0);
    rst = 1'b1;
    tick();

    // DIVU 142/12 -> q=11 r=10
    issue(F_DIVU, 32'd142, 32'd12);
    check("divu_acc_stall", stall_req, 1);
    tick();
    check("divu_funct", md_funct, F_DIVU);
    check("divu_op1", md_op1, 142);
    check("divu_op2", md_op2, 12);
    check("divu_busy_stall", stall_req, 1);
    tick();
    tick();
    check("divu_busy_stall2", stall_req, 1);
    md_done   = 1'b1;
    md_result = {32'd10, 32'd11};
    #1;
    check("divu_done_stall", stall_req, 0);
    tick();
    md_done  = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("divu_hi", hi, 10);
    check("divu_lo", lo, 11);
    check("divu_funct0", md_funct, 0);
    check("divu_idle_stall", stall_req, 0);

    // DIV 0x80000012/0x12
    issue(F_DIV, 32'h8000_0012, 32'h12);
    tick();
    check("div_funct", md_funct, F_DIV);
    tick();
    md_done   = 1'b1;
    md_result = {32'hFFFF_FFFE, 32'hF8E3_8E3A};
    tick();
    md_done = 1'b0;
    issue(F_MFHI, 32'd0, 32'd0);
    check("div_hi", hi, 64'hFFFF_FFFE);
    check("div_lo", lo, 64'hF8E3_8E3A);
    check("mfhi", hilo_rdata, 64'hFFFF_FFFE);
    check("mfhi_nostall", stall_req, 0);
    ex_funct = F_MFLO;
    #1;
    check("mflo", hilo_rdata, 64'hF8E3_8E3A);
    tick();
    check("mfhi_nolaunch", md_funct, 0);

    // MULTU 12x12 then MTLO
    issue(F_MULTU, 32'd12, 32'd12);
    tick();
    md_done   = 1'b1;
    md_result = 64'h90;
    tick();
    md_done = 1'b0;
    check("multu_hi", hi, 0);
    check("multu_lo", lo, 64'h90);
    issue(F_MTLO, 32'h55, 32'd0);
    check("mtlo_nostall", stall_req, 0);
    tick();
    ex_valid = 1'b0;
    check("mtlo_lo", lo, 64'h55);
    check("mtlo_hi", hi, 0);

    // DIVU by zero
    issue(F_DIVU, 32'd7, 32'd0);
    check("div0_nostall", stall_req, 0);
    tick();
    ex_valid = 1'b0;
    check("div0_pulse", div0, 1);
    check("div0_nolaunch", md_funct, 0);
    check("div0_hi", hi, 0);
    check("div0_lo", lo, 64'h55);
    check("div0_stall", stall_req, 0);
    tick();
    check("div0_once", div0, 0);
    tick();

    // md_done under stall_all
    issue(F_MULT, 32'd3, 32'd5);
    tick();
    stall_all = 1'b1;
    md_done   = 1'b1;
    md_result = 64'd15;
    #1;
    check("md_stall", md_stall, 1);
    tick();
    md_done = 1'b0;
    check("stl_lo", lo, 15);
    check("stl_funct0", md_funct, 0);
    check("stl_nostall", stall_req, 0);
    tick();
    tick();
    check("stl_norelaunch", md_funct, 0);
    stall_all = 1'b0;
    tick();
    ex_valid = 1'b0;
    check("stl_norelaunch2", md_funct, 0);
    issue(F_MTHI, 32'h77, 32'd0);
    tick();
    ex_valid = 1'b0;
    check("stl_idle_mthi", hi, 64'h77);

    // watchdog
    issue(F_MULTU, 32'd1, 32'd2);
    tick();
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    ex_valid = 1'b0;
    check("tout_cycles", 64'(n), 64);
    check("tout_hi", hi, 64'h77);
    check("tout_lo", lo, 15);
    check("tout_funct0", md_funct, 0);
    tick();
    check("tout_once", timeout_err, 0);
    tick();

    // reset mid-BUSY
    issue(F_DIVU, 32'd142, 32'd12);
    tick();
    tick();
    check("rstb_stall", stall_req, 1);
    ex_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("rstb_stall0", stall_req, 0);
    check("rstb_hi", hi, 0);
    check("rstb_lo", lo, 0);
    check("rstb_funct", md_funct, 0);
    tick();
    rst = 1'b1;
    tick();
    check("rstb_idle", stall_req, 0);

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
